// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: registered priority encoder with fixed-priority or round-robin search order.
// Optional feature macro: PRIO_ENC_MULTI_ERR_EN (registers a "more than one request" flag on out_multi).
module prio_encoder_rr #(
    parameter int WIDTH = 16,
    parameter int MODE  = 0,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_hit,
    output logic             out_multi,
    output logic [IDX_W-1:0] out_ptr
);

    // Returns {found, index} of the first set bit, scanning upward from start with wrap.
    // WIDTH is a power of two, so the index adder wraps for free.
    function automatic logic [IDX_W:0] find_first(input logic [WIDTH-1:0] vec,
                                                  input logic [IDX_W-1:0] start);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] pos;
        res = {(IDX_W+1){1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            pos = start + IDX_W'(i);
            if (!res[IDX_W] && vec[pos]) begin
                res = {1'b1, pos};
            end
        end
        return res;
    endfunction

    logic             out_valid_r;
    logic [IDX_W-1:0] out_idx_r;
    logic             out_hit_r;
    logic [IDX_W-1:0] ptr_r;

    logic             accept_s;
    logic [IDX_W-1:0] start_s;
    logic [IDX_W:0]   found_s;
    logic [IDX_W-1:0] idx_s;
    logic             hit_s;
    logic [IDX_W-1:0] ptr_next_s;

    // Handshake, search and pointer-advance decode.
    always_comb begin
        accept_s   = in_valid && in_ready;
        start_s    = (MODE == 1) ? ptr_r : {IDX_W{1'b0}};
        found_s    = find_first(req, start_s);
        hit_s      = found_s[IDX_W];
        idx_s      = found_s[IDX_W-1:0];
        if ((MODE == 1) && hit_s) begin
            ptr_next_s = idx_s + IDX_W'(1'b1);
        end else begin
            ptr_next_s = ptr_r;
        end
    end

    // Single output register: load on accept, drain on take, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_idx_r   <= {IDX_W{1'b0}};
            out_hit_r   <= 1'b0;
            ptr_r       <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_idx_r   <= idx_s;
            out_hit_r   <= hit_s;
            ptr_r       <= ptr_next_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`ifdef PRIO_ENC_MULTI_ERR_EN
    // More than one bit set iff clearing the lowest set bit leaves something behind.
    function automatic logic multi_bits(input logic [WIDTH-1:0] vec);
        return |(vec & (vec - {{(WIDTH-1){1'b0}}, 1'b1}));
    endfunction

    logic out_multi_r;

    // Multi-request flag travels with the result it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_multi_r <= 1'b0;
        end else if (accept_s) begin
            out_multi_r <= multi_bits(req);
        end else begin
            out_multi_r <= out_multi_r;
        end
    end

    assign out_multi = out_multi_r;
`else
    assign out_multi = 1'b0;
`endif

    assign in_ready  = !out_valid_r || out_ready;
    assign out_valid = out_valid_r;
    assign out_idx   = out_idx_r;
    assign out_hit   = out_hit_r;
    assign out_ptr   = ptr_r;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench: one fixed-priority and one round-robin instance share stimulus and handshakes.
module tb_prio_encoder_rr;
    localparam int W  = 16;
    localparam int IW = 4;
`ifdef PRIO_ENC_MULTI_ERR_EN
    localparam bit MULTI_EN = 1'b1;
`else
    localparam bit MULTI_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, in_valid, out_ready;
    logic [W-1:0]  req;
    logic          in_ready0, in_ready1, out_valid0, out_valid1;
    logic          out_hit0, out_hit1, out_multi0, out_multi1;
    logic [IW-1:0] out_idx0, out_idx1, out_ptr0, out_ptr1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int idx0;
        int idx1;
        int hit;
        int multi;
        int ptr1;
    } exp_t;

    exp_t sbq[$];
    exp_t pe, me;
    int   model_ptr = 0;

    prio_encoder_rr #(.WIDTH(W), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .req(req),
        .out_valid(out_valid0), .out_ready(out_ready), .out_idx(out_idx0),
        .out_hit(out_hit0), .out_multi(out_multi0), .out_ptr(out_ptr0));

    prio_encoder_rr #(.WIDTH(W), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .req(req),
        .out_valid(out_valid1), .out_ready(out_ready), .out_idx(out_idx1),
        .out_hit(out_hit1), .out_multi(out_multi1), .out_ptr(out_ptr1));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Lowest set index, or 0 when nothing is set.
    function automatic int ref_fixed(input logic [W-1:0] v);
        int r;
        r = -1;
        for (int i = W - 1; i >= 0; i--) if (v[i]) r = i;
        return (r < 0) ? 0 : r;
    endfunction

    // Round-robin: smallest set index at or above p, else smallest set index overall.
    function automatic int ref_rr(input logic [W-1:0] v, input int p);
        int set_q[$];
        int r;
        for (int i = 0; i < W; i++) if (v[i]) set_q.push_back(i);
        if (set_q.size() == 0) return 0;
        r = set_q[0];
        for (int k = set_q.size() - 1; k >= 0; k--) if (set_q[k] >= p) r = set_q[k];
        return r;
    endfunction

    // Predictor: on every accepted request push the expected result.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            sbq.delete();
            model_ptr = 0;
        end else if (in_valid && in_ready0) begin
            pe.hit   = (req != '0) ? 1 : 0;
            pe.multi = (MULTI_EN && ($countones(req) > 1)) ? 1 : 0;
            pe.idx0  = ref_fixed(req);
            pe.idx1  = ref_rr(req, model_ptr);
            if (pe.hit != 0) model_ptr = (pe.idx1 + 1) % W;
            pe.ptr1  = model_ptr;
            sbq.push_back(pe);
        end
    end

    // Monitor: pop and compare on every output take; check held results stay put.
    logic          held = 1'b0;
    logic [IW-1:0] h_idx0, h_idx1, h_ptr1;
    logic          h_hit0, h_multi0;
    initial forever begin
        @(negedge clk);
        if (held) begin
            chk("hold_valid0", out_valid0, 1);
            chk("hold_valid1", out_valid1, 1);
            chk("hold_idx0", out_idx0, h_idx0);
            chk("hold_idx1", out_idx1, h_idx1);
            chk("hold_hit0", out_hit0, h_hit0);
            chk("hold_multi0", out_multi0, h_multi0);
            chk("hold_ptr1", out_ptr1, h_ptr1);
        end
        held = 1'b0;
        if (!rst) begin
            chk("in_ready0", in_ready0, !out_valid0 || out_ready);
            chk("in_ready1", in_ready1, !out_valid1 || out_ready);
            chk("ptr0_zero", out_ptr0, 0);
            if ((out_valid0 || out_valid1) && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    me = sbq.pop_front();
                    chk("valid0", out_valid0, 1);
                    chk("valid1", out_valid1, 1);
                    chk("idx0", out_idx0, me.idx0);
                    chk("idx1", out_idx1, me.idx1);
                    chk("hit0", out_hit0, me.hit);
                    chk("hit1", out_hit1, me.hit);
                    chk("multi0", out_multi0, me.multi);
                    chk("multi1", out_multi1, me.multi);
                    chk("ptr1", out_ptr1, me.ptr1);
                end
            end
            if (out_valid0 && !out_ready) begin
                held     = 1'b1;
                h_idx0   = out_idx0;
                h_idx1   = out_idx1;
                h_hit0   = out_hit0;
                h_multi0 = out_multi0;
                h_ptr1   = out_ptr1;
            end
        end
    end

    // Stimulus: directed spec scenarios, then randomized traffic, then a bounded drain.
    int kind;
    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; req = '0;
        repeat (2) cyc();
        rst = 1'b0;
        chk("rst_valid0", out_valid0, 0);
        chk("rst_idx0", out_idx0, 0);
        chk("rst_hit0", out_hit0, 0);
        chk("rst_multi0", out_multi0, 0);
        chk("rst_ptr1", out_ptr1, 0);
        chk("rst_in_ready1", in_ready1, 1);

        // Zero request is still a valid result.
        in_valid = 1'b1; out_ready = 1'b1; req = 16'h0000;
        cyc();
        chk("zero_valid", out_valid0, 1);
        chk("zero_hit", out_hit0, 0);
        chk("zero_idx", out_idx0, 0);
        chk("zero_multi", out_multi0, 0);
        chk("zero_ptr1", out_ptr1, 0);
        req = 16'h0120;
        cyc();
        chk("0120_idx0", out_idx0, 5);
        chk("0120_hit0", out_hit0, 1);
        chk("0120_multi0", out_multi0, MULTI_EN ? 1 : 0);
        chk("0120_idx1", out_idx1, 5);
        in_valid = 1'b0;
        cyc();

        // Round-robin alternation from ptr 0.
        rst = 1'b1; cyc(); rst = 1'b0;
        in_valid = 1'b1; req = 16'h8001;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rr8001_idx", out_idx1, (k == 1) ? 15 : 0);
            chk("rr8001_ptr", out_ptr1, (k == 1) ? 0 : 1);
        end
        req = 16'h4000;
        cyc();
        chk("rr4000_ptr", out_ptr1, 15);
        req = 16'h8000;
        cyc();
        chk("wrap_idx", out_idx1, 15);
        chk("wrap_ptr", out_ptr1, 0);
        in_valid = 1'b0;
        cyc();

        // Backpressure: result 7 held four cycles, then take + accept with no bubble.
        out_ready = 1'b0; in_valid = 1'b1; req = 16'h0080;
        cyc();
        chk("bp_idx", out_idx0, 7);
        req = 16'h0004;
        for (int k = 0; k < 4; k++) begin
            chk("bp_in_ready", in_ready0, 0);
            chk("bp_held_idx", out_idx0, 7);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready0, 1);
        cyc();
        chk("bp_next_valid", out_valid0, 1);
        chk("bp_next_idx", out_idx0, 2);
        in_valid = 1'b0;
        cyc();

        // Reset while a result is stalled.
        out_ready = 1'b0; in_valid = 1'b1; req = 16'h0010;
        cyc();
        in_valid = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_valid0", out_valid0, 0);
        chk("midrst_valid1", out_valid1, 0);
        chk("midrst_ptr1", out_ptr1, 0);
        chk("midrst_in_ready", in_ready1, 1);
        chk("midrst_hit1", out_hit1, 0);

        // Randomized traffic with mixed request densities and occasional reset.
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            rst       = ($urandom % 64) == 0;
            kind      = $urandom % 4;
            case (kind)
                0:       req = '0;
                1:       req = W'(1) << $urandom_range(W - 1, 0);
                2:       req = W'($urandom);
                default: req = W'($urandom) & W'($urandom) & W'($urandom);
            endcase
            cyc();
        end

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 20 && sbq.size() != 0; n++) cyc();
        chk("drain_empty", sbq.size(), 0);
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/prio_encoder_rr.md
PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 16: request vector width, power of two, 2..64.
REQ-002 SHALL have parameter MODE, default 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-003 SHALL have derived localparam IDX_W = $clog2(WIDTH): index width.
REQ-004 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1: req is presented.
REQ-007 SHALL have port in_ready  output  1: block accepts req this cycle.
REQ-008 SHALL have port req  input  WIDTH: request vector, any number of bits set.
REQ-009 SHALL have port out_valid  output  1: registered result available.
REQ-010 SHALL have port out_ready  input  1: consumer takes result.
REQ-011 SHALL have port out_idx  output  IDX_W: encoded index of the selected bit.
REQ-012 SHALL have port out_hit  output  1: at least one req bit was set.
REQ-013 SHALL have port out_multi  output  1: more than one req bit was set.
REQ-014 SHALL have port out_ptr  output  IDX_W: current round-robin pointer, for debug.

Function
REQ-015 SHALL accept input when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational, single output register, full throughput).
REQ-016 SHALL present the result one cycle after acceptance: latency 1, out_valid set the cycle after the handshake.
REQ-017 SHALL hold out_idx/out_hit/out_multi/out_valid stable while out_valid && !out_ready.
REQ-018 SHALL clear out_valid on out_ready when no new input is accepted in the same cycle; simultaneous output take and input accept SHALL reload the register with out_valid remaining 1.
REQ-019 MODE 0: out_idx = lowest set bit index of req.
REQ-020 MODE 1: search order ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1; out_idx = first set bit found.
REQ-021 MODE 1: on accepted input with any bit set, ptr <= (out_idx_next + 1) mod WIDTH; wrap from WIDTH-1 to 0. Zero req or no acceptance leaves ptr unchanged.
REQ-022 MODE 0: ptr SHALL stay 0.
REQ-023 Zero req: out_hit = 0, out_idx = 0, out_multi = 0, out_valid still asserted (zero is a valid result).
REQ-024 One-hot req: out_idx equals the set-bit position in both modes, irrespective of ptr.
REQ-025 SHALL have no combinational path from req to any output; only out_ready -> in_ready is combinational.

Reset
REQ-026 On rst: out_valid = 0, out_idx = 0, out_hit = 0, out_multi = 0, ptr = 0.
REQ-027 Reset mid-transfer SHALL drop the pending result; in_ready = 1 the cycle after rst deasserts.
REQ-028 rst SHALL take priority over any simultaneous handshake.

Configuration
REQ-029 Macro PRIO_ENC_MULTI_ERR_EN: when defined, out_multi is computed (popcount(req) > 1) and registered with the result.
REQ-030 Without PRIO_ENC_MULTI_ERR_EN: out_multi is tied to 0, no detection logic is instantiated; all other behaviour is identical.

Verification
REQ-031 WIDTH=16, MODE=0, req=16'h0000 accepted -> next cycle out_valid=1, out_hit=0, out_idx=0, out_multi=0.
REQ-032 WIDTH=16, MODE=0, req=16'h0120 -> out_idx=5, out_hit=1, out_multi=1 (macro defined) / 0 (undefined).
REQ-033 WIDTH=16, MODE=1, req=16'h8001 accepted 3 times back-to-back, out_ready=1 -> out_idx 0, 15, 0; ptr 1, 0, 1.
REQ-034 Backpressure: out_ready=0 for 4 cycles after result idx=7 -> in_ready=0, out_idx held at 7; out_ready=1 with in_valid=1 -> new result next cycle, no bubble.
REQ-035 MODE=1, ptr=15, req=16'h8000 -> out_idx=15, ptr wraps to 0.
REQ-036 rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, ptr=0, in_ready=1.
